sha256_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SHA-256 compression core among `NUM_REQ` requesters, such as the bitcoin-hash nonce lanes. It accepts one 512-bit block plus chaining value from a granted requester and pulses the core's `start`. It then waits for `done` and returns the 256-bit result to that requester. Only one compression is in flight at a time.

---
 rtl/sha_arb_pkg.sv | 20 ++
 rtl/sha256_arbiter_rr_pick.sv | 32 +++
 rtl/sha256_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sha256_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_arb_pkg.sv
// Shared types and constants for the SHA-256 core arbiter and its requesters.
package sha_arb_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_WDOG_CYCLES = 255;

    localparam word_t SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] pos_s;
    logic          hit_s;
    logic          found_s;

    // Scan from last+1 upward; the first hit blocks all later candidates.
    always_comb begin
        grant   = '0;
        idx     = '0;
        pos_s   = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s        = IW'((int'(last) + k) % NUM_REQ);
            hit_s        = req[pos_s] & ~found_s;
            grant[pos_s] = hit_s;
            idx          = hit_s ? pos_s : idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin sequencer sharing one SHA-256 compression core among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SHA_ARB_WATCHDOG_EN.
module sha256_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][15:0][31:0] req_message,
    input  logic [NUM_REQ-1:0][7:0][31:0]  req_hin,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [7:0][31:0]              rsp_hash,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          core_start,
    output logic [15:0][31:0]             core_message,
    output logic [7:0][31:0]              core_hin,
    input  logic [7:0][31:0]              core_hout,
    input  logic                          core_done
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
        $error("sha256_arbiter: parameter out of range");
    end

    arb_state_e       state_r;
    arb_state_e       state_nx_s;
    logic [IW-1:0]    last_r;
    logic [IW-1:0]    gnt_r;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IW-1:0]    pick_idx_s;
    logic             accept_s;
    logic             done_s;
    logic             timeout_s;

    logic [NUM_REQ-1:0] rsp_valid_r;
    word_t [7:0]      rsp_hash_r;
    word_t [15:0]     core_message_r;
    word_t [7:0]      core_hin_r;
    logic             core_start_r;
    logic             busy_r;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .last  (last_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && (req_valid != '0);
    assign done_s    = (state_r == ST_WAIT) && core_done;
    assign req_ready = accept_s ? pick_grant_s : '0;

`ifdef SHA_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt_r;
    logic        rsp_err_r;

    assign timeout_s = (state_r == ST_WAIT) && !core_done && (wdog_cnt_r == WDOG_LAST);
    assign rsp_err   = rsp_err_r;

    // Watchdog counter: counts cycles spent in WAIT, cleared everywhere else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_r <= 16'd0;
        end else if (state_r == ST_WAIT) begin
            wdog_cnt_r <= wdog_cnt_r + 16'd1;
        end else begin
            wdog_cnt_r <= 16'd0;
        end
    end

    // Error flag: set by an abort, cleared by a real completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err_r <= 1'b0;
        end else if (done_s) begin
            rsp_err_r <= 1'b0;
        end else if (timeout_s) begin
            rsp_err_r <= 1'b1;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (done_s || timeout_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Job latches, result capture and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r         <= IW'(NUM_REQ - 1);
            gnt_r          <= '0;
            core_message_r <= '0;
            core_hin_r     <= '0;
            rsp_hash_r     <= '0;
            rsp_valid_r    <= '0;
            core_start_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            core_start_r <= accept_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            rsp_valid_r  <= (done_s || timeout_s) ? (NUM_REQ'(1) << gnt_r) : '0;
            if (accept_s) begin
                core_message_r <= req_message[pick_idx_s];
                core_hin_r     <= req_hin[pick_idx_s];
                gnt_r          <= pick_idx_s;
            end
            if (done_s) begin
                rsp_hash_r <= core_hout;
            end else if (timeout_s) begin
                rsp_hash_r <= '0;
            end
            if (state_r == ST_RESP) begin
                last_r <= gnt_r;
            end
        end
    end

    assign rsp_valid    = rsp_valid_r;
    assign rsp_hash     = rsp_hash_r;
    assign core_start   = core_start_r;
    assign core_message = core_message_r;
    assign core_hin     = core_hin_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed self-checking bench for sha256_arbiter with a 68-cycle stub core.
`timescale 1ns/1ps
module tb_sha256_arbiter;
    import sha_arb_pkg::*;

`ifdef SHA_ARB_WATCHDOG_EN
    localparam int TB_WDOG = 20;
`else
    localparam int TB_WDOG = 255;
`endif

    localparam logic [7:0][31:0] ABC_DIG = {
        32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
        32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
    };

    logic clk = 1'b0;
    logic reset_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [3:0][15:0][31:0] req_message;
    logic [3:0][7:0][31:0] req_hin;
    logic [3:0] rsp_valid;
    logic [7:0][31:0] rsp_hash;
    logic rsp_err;
    logic busy;
    logic core_start;
    logic [15:0][31:0] core_message;
    logic [7:0][31:0] core_hin;
    logic [7:0][31:0] core_hout;
    logic core_done;

    logic stub_en;
    logic stray_done;
    logic stub_done;
    int   stub_cnt;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0][31:0] iv_p;

    sha256_arbiter #(.NUM_REQ(4), .WDOG_CYCLES(TB_WDOG)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_message(req_message), .req_hin(req_hin),
        .rsp_valid(rsp_valid), .rsp_hash(rsp_hash), .rsp_err(rsp_err),
        .busy(busy), .core_start(core_start),
        .core_message(core_message), .core_hin(core_hin),
        .core_hout(core_hout), .core_done(core_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done pulse 68 cycles after the start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= stub_en && (stub_cnt == 1);
            if (core_start) stub_cnt <= 67;
            else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
        end
    end
    assign core_done = stub_done | stray_done;

    always_comb begin
        core_hout = '0;
        if (core_message[0] == 32'h61626380 && core_message[15] == 32'h00000018) begin
            core_hout = ABC_DIG;
        end else begin
            for (int i = 0; i < 8; i++) core_hout[i] = core_message[i] ^ core_hin[i] ^ core_message[i+8];
        end
    end

    function automatic logic [31:0] pmsg(int r, int w);
        return 32'h1000_0000 * (r + 1) + 32'h0000_0101 * w + 32'h7;
    endfunction
    function automatic logic [31:0] phin(int r, int i);
        return 32'hA5A5_0000 + 32'h10 * r + i;
    endfunction
    function automatic logic [7:0][31:0] exp_hash(int r);
        logic [7:0][31:0] h;
        for (int i = 0; i < 8; i++) h[i] = pmsg(r, i) ^ phin(r, i) ^ pmsg(r, i + 8);
        return h;
    endfunction

    task automatic load_req(input int r);
        for (int w = 0; w < 16; w++) req_message[r][w] = pmsg(r, w);
        for (int i = 0; i < 8; i++) req_hin[r][i] = phin(r, i);
    endtask

    task automatic load_abc(input int r);
        for (int w = 0; w < 16; w++) req_message[r][w] = 32'h0;
        req_message[r][0]  = 32'h61626380;
        req_message[r][15] = 32'h00000018;
        for (int i = 0; i < 8; i++) req_hin[r][i] = SHA256_IV[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_valid = 4'b0000;
        stray_done = 1'b0;
        stub_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 4'b0000;
        stray_done = 1'b0;
        stub_en = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, rsp_valid, core_start, busy, rsp_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h want=0", {req_ready, rsp_valid, core_start, busy, rsp_err});
        end
        checks++;
        if (rsp_hash !== '0 || core_message !== '0 || core_hin !== '0) begin
            failures++;
            $display("FAIL reset_data got hash=%h hin=%h want=0", rsp_hash, core_hin);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got busy=%b ready=%b want 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_single();
        int n;
        load_abc(1);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_ready got=%b want=0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (core_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start got start=%b busy=%b want 1/1", core_start, busy);
        end
        checks++;
        if (core_message[0] !== 32'h61626380 || core_message[15] !== 32'h00000018 || core_hin !== iv_p) begin
            failures++;
            $display("FAIL single_latch got m0=%h m15=%h hin=%h", core_message[0], core_message[15], core_hin);
        end
        step();
        checks++;
        if (core_start !== 1'b0) begin
            failures++;
            $display("FAIL single_start_width got=%b want=0", core_start);
        end
        n = 2;
        while (rsp_valid == 4'b0000 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n != 70) begin
            failures++;
            $display("FAIL single_latency got=%0d want=70", n);
        end
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got valid=%b err=%b want 0010/0", rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_hash !== ABC_DIG) begin
            failures++;
            $display("FAIL single_hash got=%h want=%h", rsp_hash, ABC_DIG);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_hash !== ABC_DIG) begin
            failures++;
            $display("FAIL single_after got valid=%b busy=%b hash=%h", rsp_valid, busy, rsp_hash);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int t_acc;
        int t_prev;
        logic [3:0] exp_g;
        apply_reset();
        for (int r = 0; r < 4; r++) load_req(r);
        req_valid = 4'b1111;
        #1;
        t_prev = 0;
        for (int j = 0; j < 5; j++) begin
            exp_g = 4'(1 << (j % 4));
            n = 0;
            while (req_ready == 4'b0000 && n < 200) begin
                step();
                n++;
            end
            t_acc = cyc;
            checks++;
            if (req_ready !== exp_g) begin
                failures++;
                $display("FAIL rr_grant job=%0d got=%b want=%b", j, req_ready, exp_g);
            end
            if (j > 0) begin
                checks++;
                if (t_acc - t_prev != 71) begin
                    failures++;
                    $display("FAIL rr_spacing job=%0d got=%0d want=71", j, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            step();
            n = 1;
            while (rsp_valid == 4'b0000 && n < 200) begin
                step();
                n++;
            end
            checks++;
            if (rsp_valid !== exp_g || n != 70) begin
                failures++;
                $display("FAIL rr_rsp job=%0d got valid=%b lat=%0d want %b/70", j, rsp_valid, n, exp_g);
            end
            checks++;
            if (rsp_hash !== exp_hash(j % 4)) begin
                failures++;
                $display("FAIL rr_hash job=%0d got=%h want=%h", j, rsp_hash, exp_hash(j % 4));
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_withdraw();
        int n;
        apply_reset();
        load_req(0);
        load_req(2);
        load_req(3);
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wd_first got=%b want=0001", req_ready);
        end
        step();
        req_valid[0] = 1'b0;
        repeat (5) step();
        req_valid[2] = 1'b0;
        req_valid[3] = 1'b1;
        n = 6;
        while (rsp_valid == 4'b0000 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_hash !== exp_hash(0)) begin
            failures++;
            $display("FAIL wd_rsp0 got valid=%b hash=%h want 0001/%h", rsp_valid, rsp_hash, exp_hash(0));
        end
        step();
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wd_next got=%b want=1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        n = 1;
        while (rsp_valid == 4'b0000 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_hash !== exp_hash(3)) begin
            failures++;
            $display("FAIL wd_rsp3 got valid=%b hash=%h want 1000/%h", rsp_valid, rsp_hash, exp_hash(3));
        end
        step();
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle got ready=%b busy=%b want 0000/0", req_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n_rsp;
        load_req(0);
        load_req(2);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rm_grant got=%b want=0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        repeat (29) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, core_start, busy, rsp_err} !== 11'd0) begin
            failures++;
            $display("FAIL rm_ctrl got=%h want=0", {req_ready, rsp_valid, core_start, busy, rsp_err});
        end
        checks++;
        if (rsp_hash !== '0 || core_message !== '0 || core_hin !== '0) begin
            failures++;
            $display("FAIL rm_data got hash=%h hin=%h want=0", rsp_hash, core_hin);
        end
        step();
        step();
        reset_n = 1'b1;
        n_rsp = 0;
        repeat (100) begin
            step();
            if (rsp_valid != 4'b0000) n_rsp++;
        end
        checks++;
        if (n_rsp != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_dropped got rsp_cycles=%0d busy=%b want 0/0", n_rsp, busy);
        end
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rm_regrant got=%b want=0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_stray_done();
        int n;
        apply_reset();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL stray_idle got busy=%b valid=%b want 0/0000", busy, rsp_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL stray_idle2 got busy=%b valid=%b want 0/0000", busy, rsp_valid);
        end
        load_req(3);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL stray_grant got=%b want=1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        stray_done = 1'b1;
        checks++;
        if (core_start !== 1'b1) begin
            failures++;
            $display("FAIL stray_issue got start=%b want=1", core_start);
        end
        step();
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL stray_in_issue got busy=%b valid=%b want 1/0000", busy, rsp_valid);
        end
        n = 2;
        while (rsp_valid == 4'b0000 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != 70 || rsp_valid !== 4'b1000 || rsp_hash !== exp_hash(3)) begin
            failures++;
            $display("FAIL stray_job got lat=%0d valid=%b hash=%h want 70/1000/%h", n, rsp_valid, rsp_hash, exp_hash(3));
        end
        step();
    endtask

`ifdef SHA_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        stub_en = 1'b0;
        load_req(1);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL wdog_grant got=%b want=0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        n = 1;
        while (rsp_valid == 4'b0000 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != 22 || rsp_valid !== 4'b0010) begin
            failures++;
            $display("FAIL wdog_timing got lat=%0d valid=%b want 22/0010", n, rsp_valid);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_hash !== '0) begin
            failures++;
            $display("FAIL wdog_abort got err=%b hash=%h want 1/0", rsp_err, rsp_hash);
        end
        step();
        stray_done = 1'b1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL wdog_idle got busy=%b valid=%b want 0/0000", busy, rsp_valid);
        end
        step();
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_hash !== '0) begin
            failures++;
            $display("FAIL wdog_late_done got busy=%b valid=%b hash=%h", busy, rsp_valid, rsp_hash);
        end
        stub_en = 1'b1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 8; i++) iv_p[i] = SHA256_IV[i];
        req_message = '0;
        req_hin = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_reset_mid();
        test_stray_done();
`ifdef SHA_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
